// File: rtl/ps2_scan_receiver_if.sv
// Key-event stream from the PS/2 receiver to its consumer.
// The master drives the head event; the slave accepts it with ev_ready.
interface ps2_scan_receiver_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_extended;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_break,
    output ev_extended,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_break,
    input  ev_extended,
    output ev_ready
  );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: pin sync + clock filter, 11-bit frame checker,
// E0/F0 prefix folding and a first-word-fall-through event FIFO.
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int CHECK_PARITY   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  ps2_scan_receiver_if.master           ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  // Two-stage synchronisers, idle-high like the bus itself.
  logic [1:0] pin_raw;
  logic [1:0] sync_bus;
  assign pin_raw = {ps2_data, ps2_clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= pin_raw[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_bus[gi] = sync_reg;
  end

  logic sync_clk;
  logic sync_data;
  assign sync_clk  = sync_bus[0];
  assign sync_data = sync_bus[1];

  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_differ;
  logic          filt_toggle;
  logic          bit_edge;

  assign filt_differ = (sync_clk != filt_clk_reg);
  assign filt_toggle = filt_differ && (filt_cnt_reg == FILT_LAST);
  assign bit_edge    = filt_toggle && filt_clk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      if (!filt_differ || filt_toggle) filt_cnt_reg <= '0;
      else                             filt_cnt_reg <= filt_cnt_reg + FW'(1);
      if (filt_toggle) filt_clk_reg <= ~filt_clk_reg;
    end
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          byte_vld_reg, byte_vld_next;
  logic          frame_err_reg, frame_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      tmo_reg       <= '0;
      byte_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      tmo_reg       <= tmo_next;
      byte_vld_reg  <= byte_vld_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    tmo_next       = tmo_reg;
    byte_vld_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (bit_edge) begin
          if (!sync_data) begin
            state_next = SHIFT;
            idx_next   = 4'd1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_edge) begin
          tmo_next = '0;
          idx_next = idx_reg + 4'd1;
          if (idx_reg <= 4'd8) begin
            shift_next = {sync_data, shift_reg[7:1]};
          end else if (idx_reg == 4'd9) begin
            parity_next = sync_data;
          end else begin
            state_next = IDLE;
            idx_next   = '0;
            // Odd parity: data plus parity bit must hold an odd number of ones.
            if (sync_data && ((CHECK_PARITY == 0) || (^{shift_reg, parity_reg})))
              byte_vld_next = 1'b1;
            else
              frame_err_next = 1'b1;
          end
        end else if (tmo_reg == TMO_LAST) begin
          state_next     = IDLE;
          idx_next       = '0;
          tmo_next       = '0;
          frame_err_next = 1'b1;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic       ext_reg;
  logic       brk_reg;
  logic       push;
  logic [9:0] push_data;

  assign push      = byte_vld_reg && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
  assign push_data = {brk_reg, ext_reg, shift_reg};

  always_ff @(posedge clk) begin
    if (rst || frame_err_reg) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (byte_vld_reg) begin
      if (shift_reg == 8'hE0) begin
        ext_reg <= 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_reg <= 1'b1;
      end else begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [9:0]    head_reg;
  logic          overflow_reg;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign full        = (count_reg == FULL_CNT);
  assign pop         = ev.ev_valid && ev.ev_ready;
  assign wr_en       = push && (!full || pop);
  assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)      count_next = count_reg + CW'(1);
    else if (!wr_en && pop) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  // Head register reads the next read address; a write landing on that
  // slot in the same cycle is forwarded so the head is never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next == '0)
        head_reg <= '0;
      else if (wr_en && (wr_ptr_reg == rd_ptr_next))
        head_reg <= push_data;
      else
        head_reg <= mem[rd_ptr_next];
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign ev.ev_valid    = (count_reg != '0);
  assign ev.ev_code     = head_reg[7:0];
  assign ev.ev_extended = head_reg[8];
  assign ev.ev_break    = head_reg[9];
  assign fifo_count     = count_reg;
  assign overflow       = overflow_reg;
  assign frame_err      = frame_err_reg;

endmodule
